// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: ROB request, CSR-file read/write port and writeback bundle.
interface csr_access_ctrl_if #(
    parameter int CSR_ADDR_W = 14,
    parameter int DATA_W     = 32,
    parameter int ROB_TAG_W  = 6
);
    logic                  RobCsrValid;
    logic                  RobCsrReady;
    logic [1:0]            RobCsrOp;
    logic [CSR_ADDR_W-1:0] RobCsrAddr;
    logic [DATA_W-1:0]     RobCsrWdata;
    logic [DATA_W-1:0]     RobCsrMask;
    logic [ROB_TAG_W-1:0]  RobCsrTag;
    logic [4:0]            RobCsrDest;
    logic                  Flush;
    logic                  CsrRAble;
    logic [CSR_ADDR_W-1:0] CsrRAddr;
    logic [DATA_W-1:0]     CsrRData;
    logic                  CsrWAble;
    logic [CSR_ADDR_W-1:0] CsrWAddr;
    logic [DATA_W-1:0]     CsrWData;
    logic                  WbValid;
    logic                  WbReady;
    logic [ROB_TAG_W-1:0]  WbTag;
    logic [4:0]            WbDest;
    logic [DATA_W-1:0]     WbData;
    logic                  WbExc;
    logic                  Busy;

    modport master (
        input  RobCsrValid, RobCsrOp, RobCsrAddr, RobCsrWdata, RobCsrMask, RobCsrTag, RobCsrDest,
               Flush, CsrRData, WbReady,
        output RobCsrReady, CsrRAble, CsrRAddr, CsrWAble, CsrWAddr, CsrWData,
               WbValid, WbTag, WbDest, WbData, WbExc, Busy
    );

    modport slave (
        output RobCsrValid, RobCsrOp, RobCsrAddr, RobCsrWdata, RobCsrMask, RobCsrTag, RobCsrDest,
               Flush, CsrRData, WbReady,
        input  RobCsrReady, CsrRAble, CsrRAddr, CsrWAble, CsrWAddr, CsrWData,
               WbValid, WbTag, WbDest, WbData, WbExc, Busy
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: serialises committed CSR ops as read, optional masked write, then writeback.
module csr_access_ctrl #(
    parameter int CSR_ADDR_W = 14,
    parameter int DATA_W     = 32,
    parameter int ROB_TAG_W  = 6
) (
    input  logic             Clk,
    input  logic             Rest,
    csr_access_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t                state_q, state_d;
    logic [CSR_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     mask_q, mask_d;
    logic [DATA_W-1:0]     old_q, old_d;
    logic [DATA_W-1:0]     new_q, new_d;
    logic [ROB_TAG_W-1:0]  tag_q, tag_d;
    logic [4:0]            dest_q, dest_d;
    logic [1:0]            op_q, op_d;
    logic                  exc_q, exc_d;
    logic                  accept;

    assign bus.RobCsrReady = (state_q == IDLE) & ~bus.Flush;
    assign accept          = bus.RobCsrValid & bus.RobCsrReady;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        old_d   = old_q;
        new_d   = new_q;
        tag_d   = tag_q;
        dest_d  = dest_q;
        op_d    = op_q;
        exc_d   = exc_q;
        if (state_q != IDLE && bus.Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_d  = bus.RobCsrAddr;
                    wdata_d = bus.RobCsrWdata;
                    mask_d  = bus.RobCsrMask;
                    tag_d   = bus.RobCsrTag;
                    dest_d  = bus.RobCsrDest;
                    op_d    = bus.RobCsrOp;
                    exc_d   = bus.RobCsrOp == OP_ILL;
                    old_d   = '0;
                    state_d = (bus.RobCsrOp == OP_ILL) ? RESP : RD;
                end
                RD:   state_d = CAP;
                CAP: begin
                    // csrxchg replaces only the bits selected by the mask
                    old_d   = bus.CsrRData;
                    new_d   = (op_q == OP_WR) ? wdata_q : (wdata_q & mask_q) | (bus.CsrRData & ~mask_q);
                    state_d = (op_q == OP_RD) ? RESP : WR;
                end
                WR:   state_d = RESP;
                RESP: state_d = bus.WbReady ? IDLE : RESP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
            tag_q   <= '0;
            dest_q  <= '0;
            op_q    <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            old_q   <= old_d;
            new_q   <= new_d;
            tag_q   <= tag_d;
            dest_q  <= dest_d;
            op_q    <= op_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.CsrRAble = state_q == RD;
    assign bus.CsrRAddr = addr_q;
    assign bus.CsrWAble = (state_q == WR) & ~bus.Flush;
    assign bus.CsrWAddr = addr_q;
    assign bus.CsrWData = new_q;
    assign bus.WbValid  = state_q == RESP;
    assign bus.WbTag    = tag_q;
    assign bus.WbDest   = dest_q;
    assign bus.WbData   = old_q;
    assign bus.WbExc    = exc_q & (state_q == RESP);
    assign bus.Busy     = state_q != IDLE;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: table vectors, corner sequences and random ops against a CSR-file model.
module tb_csr_access_ctrl;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int TW = 6;

    logic Clk = 1'b0;
    logic Rest = 1'b1;
    always #5 Clk = ~Clk;

    csr_access_ctrl_if #(.CSR_ADDR_W(AW), .DATA_W(DW), .ROB_TAG_W(TW)) bus ();
    csr_access_ctrl #(.CSR_ADDR_W(AW), .DATA_W(DW), .ROB_TAG_W(TW)) dut (
        .Clk(Clk), .Rest(Rest), .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] csr_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          poke = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;

    always @(posedge Clk) begin
        if (bus.CsrRAble) bus.CsrRData <= csr_mem[bus.CsrRAddr];
        if (bus.CsrWAble) csr_mem[bus.CsrWAddr] <= bus.CsrWData;
        if (poke) csr_mem[poke_a] <= poke_d;
    end

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
        logic [DW-1:0] init;
        logic [DW-1:0] exp_wb;
        logic [DW-1:0] exp_wr;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_csr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke = 1'b1; poke_a = a; poke_d = d; ref_mem[a] = d;
        tick();
        poke = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [DW-1:0] mk, input logic [TW-1:0] tag, input logic [4:0] dest);
        bus.RobCsrValid = 1'b1; bus.RobCsrOp = op; bus.RobCsrAddr = a;
        bus.RobCsrWdata = wd; bus.RobCsrMask = mk; bus.RobCsrTag = tag; bus.RobCsrDest = dest;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] mk, input logic [TW-1:0] tag, input logic [4:0] dest,
                          output logic [DW-1:0] wb_data, output logic [DW-1:0] wr_data);
        logic [DW-1:0] old, nv;
        logic          is_wr, exc_seen, both;
        logic [TW-1:0] tag_seen;
        logic [4:0]    dest_seen;
        logic [AW-1:0] rd_a, wr_a;
        int            rd_cyc, wr_cyc, wb_cyc, nrd, nwr;
        is_wr = (op == 2'b01) || (op == 2'b10);
        old = (op == 2'b11) ? '0 : ref_mem[a];
        nv = (op == 2'b01) ? wd : (wd & mk) | (old & ~mk);
        rd_cyc = -1; wr_cyc = -1; wb_cyc = -1; nrd = 0; nwr = 0; both = 1'b0;
        wb_data = '0; wr_data = '0; exc_seen = 1'b0; tag_seen = '0; dest_seen = '0; rd_a = '0; wr_a = '0;
        bus.WbReady = 1'b1;
        drive_req(op, a, wd, mk, tag, dest);
        #1 chk("accept_ready", bus.RobCsrReady, 1);
        tick();
        bus.RobCsrValid = 1'b0;
        for (int n = 1; n <= 12 && wb_cyc < 0; n++) begin
            #1;
            if (bus.CsrRAble && bus.CsrWAble) both = 1'b1;
            if (bus.CsrRAble) begin
                nrd++;
                if (rd_cyc < 0) rd_cyc = n;
                rd_a = bus.CsrRAddr;
            end
            if (bus.CsrWAble) begin
                nwr++; wr_cyc = n; wr_a = bus.CsrWAddr; wr_data = bus.CsrWData;
            end
            if (bus.WbValid) begin
                wb_cyc = n; wb_data = bus.WbData; exc_seen = bus.WbExc;
                tag_seen = bus.WbTag; dest_seen = bus.WbDest;
            end
            tick();
        end
        chk("wb_latency", wb_cyc, (op == 2'b00) ? 3 : (op == 2'b11) ? 1 : 4);
        chk("wb_data", wb_data, old);
        chk("wb_exc", exc_seen, op == 2'b11);
        chk("wb_tag", tag_seen, tag);
        chk("wb_dest", dest_seen, dest);
        chk("rd_count", nrd, (op == 2'b11) ? 0 : 1);
        chk("wr_count", nwr, is_wr ? 1 : 0);
        chk("rd_wr_exclusive", both, 0);
        if (op != 2'b11) begin
            chk("rd_cycle", rd_cyc, 1);
            chk("rd_addr", rd_a, a);
        end
        if (is_wr) begin
            chk("wr_cycle", wr_cyc, 3);
            chk("wr_addr", wr_a, a);
            chk("wr_data", wr_data, nv);
            ref_mem[a] = nv;
        end
        chk("idle_after", bus.Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] wb, wr, hold_d;
        logic [TW-1:0] hold_t;
        logic          got;
        int            nw, nv;
        bus.RobCsrValid = 0; bus.RobCsrOp = 0; bus.RobCsrAddr = 0; bus.RobCsrWdata = 0;
        bus.RobCsrMask = 0; bus.RobCsrTag = 0; bus.RobCsrDest = 0; bus.Flush = 0; bus.WbReady = 1;
        vecs[0] = '{2'b00, 14'h5,  32'h0,         32'h0,         32'h0000_0800, 32'h0000_0800, 32'h0};
        vecs[1] = '{2'b01, 14'h30, 32'hDEAD_BEEF, 32'h0,         32'h0000_1234, 32'h0000_1234, 32'hDEAD_BEEF};
        vecs[2] = '{2'b10, 14'h0,  32'h0000_0007, 32'h0000_0007, 32'h0000_00A8, 32'h0000_00A8, 32'h0000_00AF};
        vecs[3] = '{2'b11, 14'h12, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_0055, 32'h0,         32'h0};
        vecs[4] = '{2'b10, 14'h7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h1234_5678, 32'h1234_5678, 32'hF034_F078};
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_ready", bus.RobCsrReady, 1);
        chk("rst_rable", bus.CsrRAble, 0);
        chk("rst_wable", bus.CsrWAble, 0);
        chk("rst_wbvalid", bus.WbValid, 0);
        chk("rst_wbexc", bus.WbExc, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_wbdata", bus.WbData, 0);
        chk("rst_wbtag", bus.WbTag, 0);
        chk("rst_waddr", bus.CsrWAddr, 0);
        chk("rst_wdata", bus.CsrWData, 0);
        Rest = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            set_csr(vecs[i].addr, vecs[i].init);
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mask, TW'(i + 1), 5'(i + 3), wb, wr);
            chk("vec_wb", wb, vecs[i].exp_wb);
            chk("vec_wr", wr, vecs[i].exp_wr);
        end

        // illegal op, then writeback stalled for five cycles
        bus.WbReady = 1'b0;
        drive_req(2'b11, 14'h9, 32'h1, 32'h1, 6'h2A, 5'd9);
        tick();
        bus.RobCsrValid = 1'b0;
        #1;
        chk("ill_wbvalid", bus.WbValid, 1);
        chk("ill_exc", bus.WbExc, 1);
        chk("ill_data", bus.WbData, 0);
        chk("ill_rable", bus.CsrRAble, 0);
        hold_d = bus.WbData; hold_t = bus.WbTag;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk);
            #2;
            chk("stall_wbvalid", bus.WbValid, 1);
            chk("stall_ready", bus.RobCsrReady, 0);
            chk("stall_data", bus.WbData, hold_d);
            chk("stall_tag", bus.WbTag, 6'h2A);
            chk("stall_tag_stable", bus.WbTag, hold_t);
            chk("stall_no_strobe", bus.CsrRAble | bus.CsrWAble, 0);
        end
        bus.WbReady = 1'b1;
        tick();
        chk("stall_release_valid", bus.WbValid, 0);
        chk("stall_release_busy", bus.Busy, 0);

        // flush while capturing read data of a csrwr
        set_csr(14'h40, 32'h1111);
        drive_req(2'b01, 14'h40, 32'hABCD, 32'h0, 6'h3, 5'd4);
        tick();
        bus.RobCsrValid = 1'b0;
        tick();
        bus.Flush = 1'b1;
        #1 chk("flush_cap_busy", bus.Busy, 1);
        tick();
        bus.Flush = 1'b0;
        #1;
        chk("flush_cap_idle", bus.Busy, 0);
        nw = 0; nv = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.CsrWAble) nw++;
            if (bus.WbValid) nv++;
        end
        chk("flush_cap_no_write", nw, 0);
        chk("flush_cap_no_wb", nv, 0);
        run_op(2'b00, 14'h40, 32'h0, 32'h0, 6'h4, 5'd5, wb, wr);
        chk("flush_cap_mem", wb, 32'h1111);

        // flush in the write cycle suppresses the strobe
        set_csr(14'h41, 32'h5);
        drive_req(2'b01, 14'h41, 32'h77, 32'h0, 6'h5, 5'd6);
        tick();
        bus.RobCsrValid = 1'b0;
        tick();
        tick();
        bus.Flush = 1'b1;
        #1;
        chk("flush_wr_busy", bus.Busy, 1);
        chk("flush_wr_wable", bus.CsrWAble, 0);
        tick();
        bus.Flush = 1'b0;
        #1;
        chk("flush_wr_idle", bus.Busy, 0);
        chk("flush_wr_wbvalid", bus.WbValid, 0);
        tick();
        run_op(2'b00, 14'h41, 32'h0, 32'h0, 6'h6, 5'd7, wb, wr);
        chk("flush_wr_mem", wb, 32'h5);

        // reset while a result is waiting, then write/read the same CSR
        set_csr(14'h50, 32'h99);
        bus.WbReady = 1'b0;
        drive_req(2'b00, 14'h50, 32'h0, 32'h0, 6'h7, 5'd8);
        tick();
        bus.RobCsrValid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            got = bus.WbValid;
            if (!got) tick();
        end
        chk("rst_resp_reached", got, 1);
        Rest = 1'b1;
        tick();
        Rest = 1'b0;
        #1;
        chk("rst_resp_wbvalid", bus.WbValid, 0);
        chk("rst_resp_busy", bus.Busy, 0);
        chk("rst_resp_ready", bus.RobCsrReady, 1);
        bus.WbReady = 1'b1;
        tick();
        run_op(2'b01, 14'h50, 32'hCAFE_F00D, 32'h0, 6'h8, 5'd9, wb, wr);
        run_op(2'b00, 14'h50, 32'h0, 32'h0, 6'h9, 5'd10, wb, wr);
        chk("rw_same_addr", wb, 32'hCAFE_F00D);

        for (int a = 0; a < 8; a++) set_csr(AW'(a), $urandom);
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), $urandom, $urandom,
                   TW'($urandom), 5'($urandom), wb, wr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the CSR file's read/write interface.
- Accepts one committed CSR instruction at a time from the ROB head (csrrd, csrwr, csrxchg) and reads the old CSR value through the CSR file read port.
- For write ops, computes the new value (masked for csrxchg) and issues a single-cycle write strobe.
- Returns the old value to writeback with a valid/ready handshake. Serialises CSR ops; honours pipeline flush.

Parameters:
CSR_ADDR_W, 14, CSR address width
DATA_W, 32, CSR and GPR data width
ROB_TAG_W, 6, ROB entry tag width

Ports:
Clk  input  1  clock, all state updates on rising edge
Rest  input  1  synchronous active-high reset
RobCsrValid  input  1  ROB presents a committed CSR op
RobCsrReady  output  1  block accepts op this cycle
RobCsrOp  input  2  00 csrrd, 01 csrwr, 10 csrxchg, 11 illegal
RobCsrAddr  input  CSR_ADDR_W  target CSR number
RobCsrWdata  input  DATA_W  rd source value (write data)
RobCsrMask  input  DATA_W  rj value (xchg mask)
RobCsrTag  input  ROB_TAG_W  ROB tag
RobCsrDest  input  5  destination GPR
Flush  input  1  pipeline flush
CsrRAble  output  1  CSR read strobe
CsrRAddr  output  CSR_ADDR_W  read address
CsrRData  input  DATA_W  read data, valid the cycle after CsrRAble
CsrWAble  output  1  CSR write strobe, one cycle per op
CsrWAddr  output  CSR_ADDR_W  write address
CsrWData  output  DATA_W  write data
WbValid  output  1  result valid to writeback
WbReady  input  1  writeback accepts result
WbTag  output  ROB_TAG_W  tag of result
WbDest  output  5  destination GPR
WbData  output  DATA_W  old CSR value
WbExc  output  1  illegal op flag (INE)
Busy  output  1  state != IDLE

Behaviour:
- States: IDLE, RD, CAP, WR, RESP.
- Reset (Rest=1, highest priority): state=IDLE. All strobes, WbValid, WbExc and Busy are 0. Captured fields (addr, data, mask, tag, dest, op) are 0.
- RobCsrReady = (state==IDLE) & ~Flush.
- Accept = RobCsrValid & RobCsrReady. On accept, all inputs are latched.
- Transitions on accept:
  - op 11: go to RESP directly with WbData=0, WbExc=1. No read, no write.
  - otherwise: go to RD.
- RD: CsrRAble=1, CsrRAddr=latched addr. Next state is CAP.
- CAP: latch old=CsrRData.
  - csrrd: next state is RESP.
  - otherwise: next state is WR, with new value registered:
    - csrwr: new = Wdata.
    - csrxchg: new = (Wdata & Mask) | (old & ~Mask).
- WR: CsrWAble=1, CsrWAddr=latched addr, CsrWData=new. Next state is RESP. CsrWAble is gated by ~Flush.
- RESP: WbValid=1, WbData=old, WbExc=latched flag. Fields stay stable while WbValid & ~WbReady. Transfer on WbValid & WbReady, then next state is IDLE.
- Latency from the accept cycle (cycle 0):
  - CsrRAble at cycle 1.
  - Data captured at the cycle 2 edge.
  - CsrWAble at cycle 3 (write ops only).
  - WbValid first at cycle 3 (csrrd) or cycle 4 (csrwr/xchg); cycle 1 for illegal.
- Flush (priority below Rest), in any non-IDLE state:
  - Next state is IDLE and the op is dropped.
  - No CsrWAble is issued in the flush cycle or after.
  - WbValid is deasserted next cycle.
- A write already issued in an earlier WR cycle is not undone.
- CsrRAble and CsrWAble are never both 1 in the same cycle.
- At most one write per accepted op.
- Back-to-back ops on the same address see the prior write, because there is no overlap.
- All outputs are registered-state decodes; there is no combinational path from CsrRData to any output.

Test Plan:
1. csrrd addr 0x5; CSR ESTAT=0x0000_0800; WbReady=1 -> CsrRAble cycle 1, no CsrWAble, WbValid cycle 3, WbData=0x800, tag/dest echoed.
2. csrwr addr 0x30, Wdata=0xDEAD_BEEF; old=0x1234 -> CsrWAble cycle 3 with CsrWAddr=0x30, CsrWData=0xDEADBEEF; WbData=0x1234 at cycle 4.
3. csrxchg addr 0x0, old=0x0000_00A8, Wdata=0x0000_0007, Mask=0x0000_0007 -> CsrWData=0x0000_00AF, WbData=0xA8.
4. Op 11 -> WbValid cycle 1, WbExc=1, WbData=0, no CsrRAble/CsrWAble. Then WbReady held 0 for 5 cycles -> RobCsrReady=0 and WbData/WbTag stable throughout.
5. Flush asserted in CAP of a csrwr -> no CsrWAble ever, IDLE next cycle, WbValid never 1. Repeat with Flush in the WR cycle -> CsrWAble=0.
6. Rest asserted during RESP with WbValid=1 -> next cycle WbValid=0, Busy=0, RobCsrReady=1. Follow with csrwr then csrrd to the same address -> csrrd returns the written value.
